// File: rtl/fifo_reader.sv
// fifo_reader: read-side consumer for syn_FIFO, turning FIFO pops into a valid/ready stream.
// Latency: first out_valid two cycles after the first r_en; one word per cycle thereafter.
// Backpressure: a 2-entry buffer plus the in-flight word bounds credit; r_en drops when both are spoken for.
//
// Ports:
//   clk, rst         - clock and synchronous active-high reset
//   en               - read enable; gates new pops only
//   isEmpty, r_en    - FIFO empty flag in, pop request out
//   r_data           - FIFO read data, valid the cycle after an accepted pop
//   out_data/out_valid/out_ready - downstream stream
//   busy             - a word is buffered or in flight
//   word_cnt         - wrapping count of handed-off words
module fifo_reader #(
  parameter int d_width   = 8,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 isEmpty,
  output logic                 r_en,
  input  logic [d_width-1:0]   r_data,
  output logic [d_width-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [cnt_width-1:0] word_cnt
);

  // Buffer is a 2-deep shift register: buf0 is always the head.
  logic [1:0]           occ_q, occ_d;
  logic                 inflight_q, inflight_d;
  logic [d_width-1:0]   buf0_q, buf0_d;
  logic [d_width-1:0]   buf1_q, buf1_d;
  logic [cnt_width-1:0] word_cnt_q, word_cnt_d;

  logic                 pop_out;
  logic [1:0]           occ_after_pop;
  logic [2:0]           credit_use;

  // Outputs are forced to their reset values while rst is high so the
  // reset cycle itself already looks idle downstream.
  assign out_valid = !rst && (occ_q != 2'd0);
  assign out_data  = rst ? '0 : buf0_q;
  assign busy      = !rst && ((occ_q != 2'd0) || inflight_q);
  assign word_cnt  = rst ? '0 : word_cnt_q;

  assign pop_out       = out_valid && out_ready;
  // pop_out implies occ_q >= 1, so this never underflows.
  assign occ_after_pop = occ_q - {1'b0, pop_out};
  // Slots committed for the next cycle: survivors plus the word landing now.
  assign credit_use    = {1'b0, occ_after_pop} + {2'b00, inflight_q};

  assign r_en = en && !isEmpty && !rst && (credit_use < 3'd2);

  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    occ_d      = occ_after_pop + {1'b0, inflight_q};
    inflight_d = r_en;   // r_en already requires !isEmpty, so it is an accepted pop
    word_cnt_d = word_cnt_q + {{(cnt_width-1){1'b0}}, pop_out};

    if (pop_out) begin
      buf0_d = buf1_q;
    end
    // Tail slot is computed after the head shift so capture+pop in one
    // cycle lands the new word right behind the new head.
    if (inflight_q) begin
      if (occ_after_pop == 2'd0) begin
        buf0_d = r_data;
      end else begin
        buf1_d = r_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule
